// File: rtl/pci_bus_arbiter_if.sv
// REQ#/GNT# and bus-status bundle between the PCI masters and the central arbiter.
// Handshake: a master holds req_n low until it is done; it may drive FRAME# only
// while its gnt_n bit is low. gnt_n is registered and never has two bits low.
interface pci_bus_arbiter_if #(
  parameter int N_MASTERS = 4
) ();
  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0] req_n;
  logic                 frame_n;
  logic                 irdy_n;
  logic [N_MASTERS-1:0] gnt_n;
  logic [OW-1:0]        owner;
  logic                 owner_valid;
  logic                 bus_idle;
  logic                 timeout;
  logic [1:0]           state_dbg;

  modport master (
    output req_n, frame_n, irdy_n,
    input  gnt_n, owner, owner_valid, bus_idle, timeout, state_dbg
  );

  modport slave (
    input  req_n, frame_n, irdy_n,
    output gnt_n, owner, owner_valid, bus_idle, timeout, state_dbg
  );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin grant, bus parking, hidden arbitration and
// revocation of grants left unused. Requests are registered before arbitration.
module pci_bus_arbiter #(
  parameter int N_MASTERS    = 4,
  parameter int IDLE_TIMEOUT = 16,
  parameter int PARK_MASTER  = 0
) (
  input  logic              clk,
  input  logic              reset,
  pci_bus_arbiter_if.slave  bus
);
  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  localparam logic [1:0] ST_PARK   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;
  localparam logic [1:0] ST_SWITCH = 2'd3;

  localparam logic [OW-1:0] PARK_IDX  = OW'(PARK_MASTER);
  localparam logic [OW-1:0] LAST_IDX  = OW'(N_MASTERS - 1);
  localparam logic [7:0]    IDLE_LAST = 8'(IDLE_TIMEOUT - 1);

  logic [1:0]           state, state_nxt;
  logic [OW-1:0]        owner, owner_nxt;
  logic [OW-1:0]        target, target_nxt;
  logic [OW-1:0]        rr_ptr, rr_nxt;
  logic [7:0]           idle_cnt;
  logic [N_MASTERS-1:0] req_q;
  logic [N_MASTERS-1:0] gnt_q, gnt_nxt;
  logic                 owner_valid_q;
  logic                 bus_idle_q;
  logic                 timeout_q, timeout_nxt;

  // Returns {found, index} of the first active bit scanning start, start+1, ... mod N.
  function automatic logic [OW:0] pick(input logic [N_MASTERS-1:0] act,
                                       input logic [OW-1:0] start);
    logic          found;
    logic [OW-1:0] sel;
    logic [OW-1:0] idx;
    int            i;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      i   = (int'(start) + k) % N_MASTERS;
      idx = OW'(i);
      if (!found && act[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  logic [N_MASTERS-1:0] req_act;
  logic [N_MASTERS-1:0] own_mask;
  logic [OW-1:0]        owner_inc;
  logic [OW:0]          win, win_other, win_after;

  always_comb begin
    req_act         = ~req_q;
    own_mask        = '0;
    own_mask[owner] = 1'b1;
    owner_inc       = (owner == LAST_IDX) ? '0 : owner + 1'b1;
    win             = pick(req_act, rr_ptr);
    win_other       = pick(req_act & ~own_mask, rr_ptr);
    win_after       = pick(req_act & ~own_mask, owner_inc);
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    target_nxt  = target;
    rr_nxt      = rr_ptr;
    timeout_nxt = 1'b0;
    case (state)
      ST_PARK: begin
        if (win[OW]) begin
          if (win[OW-1:0] == owner) begin
            state_nxt = ST_GRANT;
          end else begin
            target_nxt = win[OW-1:0];
            state_nxt  = ST_SWITCH;
          end
        end else if (owner != PARK_IDX) begin
          // Parked on a master that dropped its request during turnaround.
          target_nxt = PARK_IDX;
          state_nxt  = ST_SWITCH;
        end
      end
      ST_GRANT: begin
        if (!bus.frame_n) begin
          state_nxt = ST_BUSY;
          rr_nxt    = owner_inc;
        end else if (req_q[owner]) begin
          target_nxt = win[OW] ? win[OW-1:0] : PARK_IDX;
          state_nxt  = ST_SWITCH;
        end else if (bus_idle_q && idle_cnt == IDLE_LAST) begin
          timeout_nxt = 1'b1;
          rr_nxt      = owner_inc;
          target_nxt  = win_after[OW] ? win_after[OW-1:0] : PARK_IDX;
          state_nxt   = ST_SWITCH;
        end
      end
      ST_BUSY: begin
        if (win_other[OW]) begin
          target_nxt = win_other[OW-1:0];
          state_nxt  = ST_SWITCH;
        end else if (bus.frame_n && bus.irdy_n) begin
          if (!req_q[owner]) begin
            state_nxt = ST_GRANT;
          end else begin
            target_nxt = PARK_IDX;
            state_nxt  = (owner == PARK_IDX) ? ST_PARK : ST_SWITCH;
          end
        end
      end
      default: begin
        owner_nxt = target;
        state_nxt = req_q[target] ? ST_PARK : ST_GRANT;
      end
    endcase
  end

  always_comb begin
    gnt_nxt = '1;
    if (state_nxt != ST_SWITCH) gnt_nxt[owner_nxt] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_SWITCH;
      owner         <= PARK_IDX;
      target        <= PARK_IDX;
      rr_ptr        <= '0;
      idle_cnt      <= '0;
      req_q         <= '1;
      gnt_q         <= '1;
      owner_valid_q <= 1'b0;
      bus_idle_q    <= 1'b1;
      timeout_q     <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      target        <= target_nxt;
      rr_ptr        <= rr_nxt;
      req_q         <= bus.req_n;
      gnt_q         <= gnt_nxt;
      owner_valid_q <= (state_nxt == ST_GRANT) || (state_nxt == ST_BUSY);
      bus_idle_q    <= bus.frame_n & bus.irdy_n;
      timeout_q     <= timeout_nxt;
      // Counter only lives while the grant stays unused; any exit or re-entry clears it.
      if (state == ST_GRANT && state_nxt == ST_GRANT) begin
        if (bus_idle_q && bus.frame_n) idle_cnt <= idle_cnt + 8'd1;
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  assign bus.gnt_n       = gnt_q;
  assign bus.owner       = owner;
  assign bus.owner_valid = owner_valid_q;
  assign bus.bus_idle    = bus_idle_q;
  assign bus.timeout     = timeout_q;
  assign bus.state_dbg   = state;
endmodule
